// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for seg_display_arbiter: per-requester request and
// word in, current owner and the registered display word out.
interface seg_display_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0][31:0]   req_data;
    logic [N_REQ-1:0]         grant;
    logic [31:0]              disp_data;
    logic                     disp_blank;
    logic                     grant_change;

    // Application side: raises requests and offers words.
    modport master (
        output req, req_data,
        input  grant, disp_data, disp_blank, grant_change
    );

    // Arbiter side: owns the display outputs.
    modport slave (
        input  req, req_data,
        output grant, disp_data, disp_blank, grant_change
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin, minimum-dwell arbiter time-sharing one 8-digit hex display
// between N_REQ requesters; blanks the display when nobody asks for it.
module seg_display_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    seg_display_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD  = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state, nxt_state;
    logic [IW-1:0]    owner, nxt_owner;
    logic [IW-1:0]    ptr, nxt_ptr;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [N_REQ-1:0] nxt_grant;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cidx;

    // Scan ptr+N down to ptr+1 so the nearest requester after ptr overwrites
    // the others; the current owner (== ptr) is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cidx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cidx = IW'((int'(ptr) + k) % N_REQ);
            if (bus.req[cidx]) begin
                win_vld = 1'b1;
                win_idx = cidx;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_ptr   = ptr;
        nxt_cnt   = cnt;
        nxt_grant = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    nxt_state = OWN;
                    nxt_owner = win_idx;
                    nxt_ptr   = win_idx;
                    nxt_cnt   = RELOAD;
                end
            end
            OWN: begin
                if (!bus.req[owner]) begin
                    if (win_vld) begin
                        nxt_owner = win_idx;
                        nxt_ptr   = win_idx;
                        nxt_cnt   = RELOAD;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (cnt == '0) begin
                    // Owner still requesting, so win_vld holds; with no other
                    // requester the search lands back on the owner.
                    nxt_owner = win_idx;
                    nxt_ptr   = win_idx;
                    nxt_cnt   = RELOAD;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (nxt_state == OWN) nxt_grant[nxt_owner] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            owner            <= '0;
            ptr              <= PTR_RST;
            cnt              <= '0;
            bus.grant        <= '0;
            bus.disp_data    <= '0;
            bus.disp_blank   <= 1'b1;
            bus.grant_change <= 1'b0;
        end else begin
            state            <= nxt_state;
            owner            <= nxt_owner;
            ptr              <= nxt_ptr;
            cnt              <= nxt_cnt;
            bus.grant        <= nxt_grant;
            bus.disp_blank   <= (nxt_grant == '0);
            bus.grant_change <= (nxt_grant != bus.grant);
            // Follows the registered owner, so data lags grant by one cycle.
            bus.disp_data    <= (state == OWN) ? bus.req_data[owner] : 32'h0;
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: stimulus queues expected grant
// changes and display words by cycle, an independent monitor checks them.
module tb_seg_display_arbiter;
    localparam int N = 4;
    localparam int D = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    seg_display_arbiter_if #(.N_REQ(N)) bus ();

    seg_display_arbiter #(.N_REQ(N), .DWELL_CYCLES(D)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int cyc; logic [3:0]  grant;} gexp_t;
    typedef struct {int cyc; logic [31:0] data;}  dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t ge;
    dexp_t de;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h1234_5678;
    localparam logic [31:0] D3 = 32'h4444_0003;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic gpush(input int c, input logic [3:0] g);
        gq.push_back('{cyc: c, grant: g});
    endtask

    task automatic dpush(input int c, input logic [31:0] d);
        dq.push_back('{cyc: c, data: d});
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        chk("disp_blank", {31'h0, bus.disp_blank}, {31'h0, (bus.grant == '0)});
        if (bus.grant_change) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_change_unexpected: got grant %b expected no change (cycle %0d)",
                         bus.grant, cyc);
            end else begin
                ge = gq.pop_front();
                chk("grant", {28'h0, bus.grant}, {28'h0, ge.grant});
                chk("grant_cycle", cyc, ge.cyc);
            end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
            ge = gq.pop_front();
            checks++;
            errors++;
            $display("FAIL grant_change_missing: got grant %b expected change to %b at cycle %0d",
                     bus.grant, ge.grant, ge.cyc);
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            de = dq.pop_front();
            chk("disp_data", bus.disp_data, de.data);
        end
    end

    int c;

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_data[0] = D0;
        bus.req_data[1] = D1;
        bus.req_data[2] = D2;
        bus.req_data[3] = D3;
        #1 reset_n = 1'b0;
        bus.req = 4'b1111;

        // Reset held with everyone requesting.
        repeat (3) @(negedge clock);
        chk("rst_grant", {28'h0, bus.grant}, 32'h0);
        chk("rst_blank", {31'h0, bus.disp_blank}, 32'h1);
        chk("rst_data", bus.disp_data, 32'h0);
        chk("rst_gchg", {31'h0, bus.grant_change}, 32'h0);

        // Release: requester 0 first, then full rotation with 8-cycle dwell.
        c = cyc;
        reset_n = 1'b1;
        gpush(c + 1, 4'b0001);
        gpush(c + 9, 4'b0010);
        gpush(c + 17, 4'b0100);
        gpush(c + 25, 4'b1000);
        gpush(c + 33, 4'b0001);
        dpush(c + 1, 32'h0);
        dpush(c + 2, D0);
        dpush(c + 9, D0);
        dpush(c + 10, D1);
        dpush(c + 18, D2);
        dpush(c + 26, D3);
        dpush(c + 34, D0);
        repeat (35) @(negedge clock);

        // Everyone drops: blank one cycle later, data zero the cycle after.
        c = cyc;
        bus.req = 4'b0000;
        gpush(c + 1, 4'b0000);
        dpush(c + 1, D0);
        dpush(c + 2, 32'h0);
        repeat (4) @(negedge clock);

        // Single requester keeps the display with no further changes.
        c = cyc;
        bus.req = 4'b0100;
        gpush(c + 1, 4'b0100);
        dpush(c + 1, 32'h0);
        dpush(c + 2, D2);
        dpush(c + 25, D2);
        repeat (30) @(negedge clock);
        c = cyc;
        bus.req = 4'b0000;
        gpush(c + 1, 4'b0000);
        dpush(c + 2, 32'h0);
        repeat (3) @(negedge clock);

        // Early release: owner 1 drops on dwell cycle 3 while 3 waits.
        c = cyc;
        bus.req = 4'b0010;
        gpush(c + 1, 4'b0010);
        dpush(c + 2, D1);
        dpush(c + 4, D1);
        @(negedge clock);
        bus.req = 4'b1010;
        repeat (2) @(negedge clock);
        bus.req = 4'b1000;
        gpush(c + 4, 4'b1000);
        dpush(c + 5, D3);
        repeat (2) @(negedge clock);

        // Skip: 0 and 3 alternate on dwell expiry, 1 and 2 are skipped.
        bus.req = 4'b1001;
        gpush(c + 12, 4'b0001);
        gpush(c + 20, 4'b1000);
        gpush(c + 28, 4'b0001);
        dpush(c + 13, D0);
        dpush(c + 21, D3);
        dpush(c + 29, D0);
        repeat (25) @(negedge clock);
        bus.req = 4'b0000;
        gpush(c + 31, 4'b0000);
        dpush(c + 32, 32'h0);
        repeat (4) @(negedge clock);

        // Live data tracking with a one-cycle lag.
        c = cyc;
        bus.req = 4'b0001;
        gpush(c + 1, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            bus.req_data[0] = 32'hA5A5_0000 + 32'(k);
            dpush(c + 2 + k, 32'hA5A5_0000 + 32'(k));
        end
        repeat (2) @(negedge clock);

        // Mid-dwell asynchronous reset; restart must favour requester 0.
        bus.req = 4'b0101;
        reset_n = 1'b0;
        #1;
        chk("async_rst_grant", {28'h0, bus.grant}, 32'h0);
        chk("async_rst_blank", {31'h0, bus.disp_blank}, 32'h1);
        chk("async_rst_data", bus.disp_data, 32'h0);
        chk("async_rst_gchg", {31'h0, bus.grant_change}, 32'h0);
        repeat (2) @(negedge clock);
        c = cyc;
        reset_n = 1'b1;
        gpush(c + 1, 4'b0001);
        dpush(c + 2, 32'hA5A5_0005);
        repeat (3) @(negedge clock);
        bus.req = 4'b0000;
        gpush(c + 4, 4'b0000);
        dpush(c + 5, 32'h0);

        for (int i = 0; i < 20 && (gq.size() > 0 || dq.size() > 0); i++) @(negedge clock);
        repeat (2) @(negedge clock);
        while (gq.size() > 0) begin
            ge = gq.pop_front();
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no change expected grant %b at cycle %0d", ge.grant, ge.cyc);
        end
        while (dq.size() > 0) begin
            de = dq.pop_front();
            checks++;
            errors++;
            $display("FAIL data_timeout: got no sample expected %h at cycle %0d", de.data, de.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the 8-digit seven-segment display between up to N_REQ independent requesters, each offering a 32-bit hex word. Sits between the application blocks and the existing scanning LED driver, whose `data` input it feeds. Round-robin grant with a minimum dwell time per owner gives each requester a readable on-screen slot. When nobody requests, the display is blanked.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DWELL_CYCLES, 100_000_000, minimum clock cycles an owner holds the display while others wait (≥2; 1 s at 100 MHz)
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester, level, held while display is wanted
- req_data  in  32*N_REQ  requester i's word at bits [32*i+31:32*i]
- grant  out  N_REQ  one-hot (or zero) current owner, registered
- disp_data  out  32  word to LED driver, registered
- disp_blank  out  1  1 = no owner; the top level forces all anodes off
- grant_change  out  1  one-cycle pulse on every change of grant, including to/from zero

One clock; reset is asynchronous and active-low (`clock`, `reset_n`).

## Operation
- State: IDLE (grant=0) or OWN (grant=one-hot owner). Registers: owner index, last-owner pointer `ptr`, dwell counter `cnt` (width clog2(DWELL_CYCLES)).
- Round-robin search: starting at ptr+1 mod N_REQ, first index with req=1 wins. ptr updates to the new owner on every grant.
- IDLE: if any req, grant the search winner, cnt <= DWELL_CYCLES-1, go OWN. Otherwise stay.
- OWN, each cycle, in priority order:
  1. Owner's req=0: release. If another req is set, grant the search winner in the same edge (reload cnt). Otherwise go IDLE.
  2. cnt==0 and some other req set: grant the search winner, reload cnt.
  3. cnt==0, no other req: keep owner, reload cnt.
  4. Else: cnt <= cnt-1.
- Requests from non-owners never preempt before the dwell expires; no priority levels.
- disp_data <= req_data slice of the owner selected by the *registered* grant, updated every cycle (live tracking of the owner's changing word). In IDLE, disp_data <= 0.
- disp_blank <= 1 when the next grant is zero, else 0; aligned with grant.
- grant_change <= 1 on any edge where the next grant differs from the current grant.
- A req bit that toggles for one cycle is honoured only if it is sampled high at an arbitration point.

## Timing
- Reset values: grant=0, disp_data=0, disp_blank=1, grant_change=0, ptr=N_REQ-1 (so requester 0 wins first), cnt=0, state IDLE.
- req rises at edge t (sampled) -> grant/disp_blank/grant_change at t+1 -> disp_data valid at t+2.
- Owner req drop sampled at t -> new grant (or zero) at t+1; old owner's data still on disp_data at t+1, new data at t+2.
- Dwell: with contention, owner keeps grant for exactly DWELL_CYCLES cycles from its grant edge, then switches.
- Simultaneous dwell expiry and owner drop: rule 1 applies (same outcome, search from ptr).
- reset_n low at any time: all outputs take reset values immediately (asynchronous); first grant after release follows IDLE rules.

## Test plan
- Reset: hold reset_n=0 with req=4'b1111 -> grant=0, disp_blank=1, disp_data=0; release -> grant=4'b0001 one cycle later, grant_change pulses once.
- Single requester: DWELL_CYCLES=8, req=4'b0100, req_data[95:64]=32'h1234_5678 -> grant=4'b0100 forever, disp_data=32'h1234_5678 from 2nd cycle, no further grant_change.
- Rotation: DWELL_CYCLES=8, req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each held exactly 8 cycles, grant_change every 8th cycle.
- Early release: owner 1 drops req at cycle 3 of dwell while req[3]=1 -> grant=4'b1000 the next cycle, disp_data shows requester 3's word one cycle later.
- Skip and idle: req=4'b1001, then all req drop -> grant alternates 0001/1000; after drop grant=0, disp_blank=1, disp_data=0, grant_change pulses once.
- Live data and mid-op reset: owner changes req_data each cycle -> disp_data follows with 1-cycle lag; assert reset_n low mid-dwell -> outputs at reset values in same cycle, restart grants requester 0.
